// File: rtl/pm_boot_loader.sv
// pm_boot_loader: byte-stream boot loader for program memory.
// Assembles a framed byte stream (LEN_LO, LEN_HI, N x {DATA_LO, DATA_HI}[, CHK])
// into 16-bit program-memory writes and holds the core in reset until the
// image has been accepted.
// Optional feature macro: BOOT_CHECKSUM_EN adds the trailing XOR checksum byte
// and its check; without it the frame ends after the last data word.
module pm_boot_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [15:0] BASE_ADDR = 16'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  input  logic        i_rearm,
  output logic        o_pm_we,
  output logic [15:0] o_pm_addr,
  output logic [15:0] o_pm_wdata,
  output logic        o_core_reset,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  // Largest legal word count: the full program memory.
  localparam logic [16:0] CAP = 17'd1 << ADDR_W;

  state_t      state_q;
  logic        rx_ready_q;
  logic        pm_we_q;
  logic [15:0] pm_addr_q;
  logic [15:0] pm_wdata_q;
  logic        core_reset_q;
  logic        done_q;
  logic        error_q;
  logic [15:0] len_q;
  logic [15:0] idx_q;
  logic [7:0]  lo_q;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  chk_q;
`endif

  logic        rx_fire_d;
  logic [15:0] len_d;
  logic [15:0] wr_addr_d;
  logic        len_ovf_d;
  logic        last_word_d;

  // Byte handshake and values derived from the byte on the bus this cycle.
  always_comb begin
    rx_fire_d   = i_rx_valid & rx_ready_q;
    len_d       = {i_rx_data, len_q[7:0]};
    wr_addr_d   = BASE_ADDR + idx_q;
    len_ovf_d   = {1'b0, len_d} > CAP;
    last_word_d = (idx_q == len_q - 16'd1);
  end

  // Frame FSM with all outputs registered.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_LEN_LO;
      rx_ready_q   <= 1'b1;
      pm_we_q      <= 1'b0;
      pm_addr_q    <= BASE_ADDR;
      pm_wdata_q   <= 16'h0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      len_q        <= 16'h0;
      idx_q        <= 16'h0;
      lo_q         <= 8'h0;
`ifdef BOOT_CHECKSUM_EN
      chk_q        <= 8'h0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse.
      pm_we_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      // Running XOR covers every accepted byte, the length bytes included.
      if (rx_fire_d) chk_q <= chk_q ^ i_rx_data;
`endif
      case (state_q)
        S_LEN_LO: begin
          if (rx_fire_d) begin
            len_q[7:0] <= i_rx_data;
            state_q    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (rx_fire_d) begin
            len_q <= len_d;
            if (len_ovf_d) begin
              state_q    <= S_ERROR;
              error_q    <= 1'b1;
              rx_ready_q <= 1'b0;
            end else if (len_d == 16'h0) begin
`ifdef BOOT_CHECKSUM_EN
              state_q      <= S_CHK;
`else
              state_q      <= S_DONE;
              done_q       <= 1'b1;
              core_reset_q <= 1'b0;
              rx_ready_q   <= 1'b0;
`endif
            end else begin
              state_q <= S_DATA_LO;
            end
          end
        end
        S_DATA_LO: begin
          if (rx_fire_d) begin
            lo_q    <= i_rx_data;
            state_q <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (rx_fire_d) begin
            pm_we_q    <= 1'b1;
            pm_addr_q  <= wr_addr_d;
            pm_wdata_q <= {i_rx_data, lo_q};
            idx_q      <= idx_q + 16'd1;
            if (last_word_d) begin
`ifdef BOOT_CHECKSUM_EN
              state_q      <= S_CHK;
`else
              state_q      <= S_DONE;
              done_q       <= 1'b1;
              core_reset_q <= 1'b0;
              rx_ready_q   <= 1'b0;
`endif
            end else begin
              state_q <= S_DATA_LO;
            end
          end
        end
        S_CHK: begin
`ifdef BOOT_CHECKSUM_EN
          if (rx_fire_d) begin
            rx_ready_q <= 1'b0;
            if ((chk_q ^ i_rx_data) == 8'h0) begin
              state_q      <= S_DONE;
              done_q       <= 1'b1;
              core_reset_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
`else
          // Unreachable without the checksum byte; recover to a safe start.
          state_q <= S_LEN_LO;
`endif
        end
        S_DONE, S_ERROR: begin
          if (i_rearm) begin
            state_q      <= S_LEN_LO;
            rx_ready_q   <= 1'b1;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            idx_q        <= 16'h0;
`ifdef BOOT_CHECKSUM_EN
            chk_q        <= 8'h0;
`endif
          end
        end
        default: begin
          state_q <= S_LEN_LO;
        end
      endcase
    end
  end

  assign o_rx_ready   = rx_ready_q;
  assign o_pm_we      = pm_we_q;
  assign o_pm_addr    = pm_addr_q;
  assign o_pm_wdata   = pm_wdata_q;
  assign o_core_reset = core_reset_q;
  assign o_done       = done_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_pm_boot_loader.sv
// Testbench for pm_boot_loader: scoreboard of expected program-memory writes,
// one task per scenario. Follows the BOOT_CHECKSUM_EN setting of the build.
module tb_pm_boot_loader;

  localparam int          ADDR_W = 10;
  localparam logic [15:0] BASE   = 16'h0;

  logic        i_clk;
  logic        i_reset;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_rx_ready;
  logic        i_rearm;
  logic        o_pm_we;
  logic [15:0] o_pm_addr;
  logic [15:0] o_pm_wdata;
  logic        o_core_reset;
  logic        o_done;
  logic        o_error;

  pm_boot_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx_valid   (i_rx_valid),
    .i_rx_data    (i_rx_data),
    .o_rx_ready   (o_rx_ready),
    .i_rearm      (i_rearm),
    .o_pm_we      (o_pm_we),
    .o_pm_addr    (o_pm_addr),
    .o_pm_wdata   (o_pm_wdata),
    .o_core_reset (o_core_reset),
    .o_done       (o_done),
    .o_error      (o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] frame_words[$];
  int          total;
  int          bad;
  int          nwrites;

  // Advance one cycle, sample #1 after the edge and retire scoreboard entries.
  task automatic tick();
    wr_t e;
    @(posedge i_clk);
    #1;
    if (o_pm_we) begin
      nwrites++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h, wanted no write", o_pm_addr, o_pm_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({o_pm_addr, o_pm_wdata} !== {e.a, e.d}) begin
          bad++;
          $display("FAIL write_value: got addr=%h data=%h, wanted addr=%h data=%h",
                   o_pm_addr, o_pm_wdata, e.a, e.d);
        end
      end
    end else if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL write_latency: got we=0, wanted write of addr=%h data=%h", exp_q[0].a, exp_q[0].d);
      exp_q.delete();
    end
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b, input bit is_hi,
                           input logic [15:0] ea, input logic [15:0] ed);
    int  n;
    bit  fin;
    wr_t e;
    n   = 0;
    fin = 1'b0;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    while (!fin) begin
      if (o_rx_ready) begin
        if (is_hi) begin
          e.a = ea;
          e.d = ed;
          exp_q.push_back(e);
        end
        fin = 1'b1;
      end
      tick();
      n++;
      if (!fin && n > 20) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: byte %h not accepted, ready=%b wanted 1", b, o_rx_ready);
        fin = 1'b1;
      end
    end
    i_rx_valid = 1'b0;
  endtask

  // Send a complete frame built from frame_words; chk_xor corrupts the checksum.
  task automatic send_frame(input bit gapped, input logic [7:0] chk_xor);
    logic [15:0] n;
    logic [7:0]  c;
    logic [15:0] w;
    n = 16'(frame_words.size());
    c = n[7:0] ^ n[15:8];
    send_byte(n[7:0], 1'b0, 16'h0, 16'h0);
    if (gapped) tick();
    send_byte(n[15:8], 1'b0, 16'h0, 16'h0);
    if (gapped) tick();
    for (int i = 0; i < frame_words.size(); i++) begin
      w = frame_words[i];
      c = c ^ w[7:0] ^ w[15:8];
      send_byte(w[7:0], 1'b0, 16'h0, 16'h0);
      if (gapped) tick();
      send_byte(w[15:8], 1'b1, BASE + 16'(i), w);
      if (gapped) tick();
    end
`ifdef BOOT_CHECKSUM_EN
    send_byte(c ^ chk_xor, 1'b0, 16'h0, 16'h0);
`else
    if (chk_xor != 8'h0) c = 8'h0;
`endif
  endtask

  // Pulse rearm and confirm the loader is back at the frame start.
  task automatic do_rearm(input string name);
    i_rearm = 1'b1;
    tick();
    i_rearm = 1'b0;
    total++;
    if ({o_rx_ready, o_core_reset, o_done, o_error} !== 4'b1100) begin
      bad++;
      $display("FAIL %s_rearm: got rdy/crst/done/err=%b, wanted 1100", name,
               {o_rx_ready, o_core_reset, o_done, o_error});
    end
  endtask

  task automatic test_reset();
    i_reset    = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h0;
    i_rearm    = 1'b0;
    tick();
    tick();
    i_reset = 1'b0;
    tick();
    total++;
    if ({o_rx_ready, o_core_reset, o_done, o_error} !== 4'b1100) begin
      bad++;
      $display("FAIL reset_status: got %b, wanted 1100", {o_rx_ready, o_core_reset, o_done, o_error});
    end
    total++;
    if ({o_pm_we, o_pm_addr, o_pm_wdata} !== {1'b0, BASE, 16'h0}) begin
      bad++;
      $display("FAIL reset_write_port: got we=%b addr=%h data=%h, wanted 0 %h 0000",
               o_pm_we, o_pm_addr, o_pm_wdata, BASE);
    end
  endtask

  // Common end-of-load check: status bits and number of writes.
  task automatic test_load(input string name, input bit gapped, input logic [7:0] chk_xor,
                           input logic [3:0] want_st, input int want_wr);
    int nw0;
    nw0 = nwrites;
    send_frame(gapped, chk_xor);
    tick();
    total++;
    if ({o_rx_ready, o_core_reset, o_done, o_error} !== want_st) begin
      bad++;
      $display("FAIL %s_status: got rdy/crst/done/err=%b, wanted %b", name,
               {o_rx_ready, o_core_reset, o_done, o_error}, want_st);
    end
    total++;
    if (nwrites - nw0 !== want_wr) begin
      bad++;
      $display("FAIL %s_writes: got %0d, wanted %0d", name, nwrites - nw0, want_wr);
    end
    do_rearm(name);
  endtask

  task automatic test_hold_in_done();
    int nw0;
    frame_words = '{16'h1234, 16'h5678};
    send_frame(1'b0, 8'h0);
    nw0 = nwrites;
    i_rx_valid = 1'b1;
    i_rx_data  = 8'hAA;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if ({o_rx_ready, o_done, nwrites - nw0} !== {1'b0, 1'b1, 32'd0}) begin
      bad++;
      $display("FAIL hold_in_done: got rdy=%b done=%b writes=%0d, wanted 0 1 0",
               o_rx_ready, o_done, nwrites - nw0);
    end
    i_rx_valid = 1'b0;
    do_rearm("hold");
  endtask

  task automatic test_overflow();
    int nw0;
    nw0 = nwrites;
    send_byte(8'h01, 1'b0, 16'h0, 16'h0);
    send_byte(8'h04, 1'b0, 16'h0, 16'h0);
    total++;
    if ({o_rx_ready, o_core_reset, o_done, o_error} !== 4'b0101) begin
      bad++;
      $display("FAIL overflow_status: got %b, wanted 0101", {o_rx_ready, o_core_reset, o_done, o_error});
    end
    tick();
    total++;
    if (nwrites - nw0 !== 0) begin
      bad++;
      $display("FAIL overflow_writes: got %0d, wanted 0", nwrites - nw0);
    end
    do_rearm("overflow");
  endtask

  task automatic test_rearm_ignored();
    logic [7:0] c;
    c = 8'h01 ^ 8'hEF ^ 8'hBE;
    i_rearm = 1'b1;
    send_byte(8'h01, 1'b0, 16'h0, 16'h0);
    send_byte(8'h00, 1'b0, 16'h0, 16'h0);
    i_rearm = 1'b0;
    send_byte(8'hEF, 1'b0, 16'h0, 16'h0);
    send_byte(8'hBE, 1'b1, BASE, 16'hBEEF);
`ifdef BOOT_CHECKSUM_EN
    send_byte(c, 1'b0, 16'h0, 16'h0);
`endif
    total++;
    if ({o_rx_ready, o_core_reset, o_done, o_error} !== 4'b0010) begin
      bad++;
      $display("FAIL rearm_ignored: got %b (chk %h), wanted 0010", {o_rx_ready, o_core_reset, o_done, o_error}, c);
    end
    do_rearm("ignored");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h02, 1'b0, 16'h0, 16'h0);
    send_byte(8'h00, 1'b0, 16'h0, 16'h0);
    send_byte(8'h34, 1'b0, 16'h0, 16'h0);
    #2 i_reset = 1'b1;
    #2;
    total++;
    if ({o_rx_ready, o_core_reset, o_done, o_error, o_pm_we, o_pm_addr} !== {5'b11000, BASE}) begin
      bad++;
      $display("FAIL reset_mid: got status=%b we=%b addr=%h, wanted 1100 0 %h",
               {o_rx_ready, o_core_reset, o_done, o_error}, o_pm_we, o_pm_addr, BASE);
    end
    i_reset = 1'b0;
    tick();
    frame_words = '{16'h1234, 16'h5678};
    test_load("replay", 1'b0, 8'h0, 4'b0010, 2);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    nwrites = 0;
    test_reset();
    frame_words = '{16'h1234, 16'h5678};
    test_load("t1_load", 1'b0, 8'h0, 4'b0010, 2);
    test_hold_in_done();
`ifdef BOOT_CHECKSUM_EN
    frame_words = '{16'h1234, 16'h5678};
    test_load("t2_badchk", 1'b0, 8'h01, 4'b0101, 2);
`endif
    test_overflow();
    frame_words.delete();
    test_load("t4_empty", 1'b0, 8'h0, 4'b0010, 0);
    frame_words = '{16'h1234, 16'h5678};
    test_load("t5_gapped", 1'b1, 8'h0, 4'b0010, 2);
    frame_words.delete();
    for (int i = 0; i < 1024; i++) frame_words.push_back(16'(i * 16'h0101) ^ 16'hA5C3);
    test_load("max_len", 1'b0, 8'h0, 4'b0010, 1024);
    test_rearm_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
